// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button debounce, run/pause/done FSM, count/load
// strobes, direction latch, terminal-count detection and done-state blink.
`timescale 1ns/1ps
module stopwatch_ctrl #(
  parameter int unsigned DB_COUNT    = 1000000,
  parameter int unsigned DB_W        = 20,
  parameter int unsigned BLINK_TICKS = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_10ms,
  input  logic start_btn,
  input  logic load_sw,
  input  logic dec_sw,
  input  logic count_zero,
  input  logic count_max,
  output logic count_en,
  output logic load_pulse,
  output logic dir_down,
  output logic running,
  output logic done,
  output logic blank
);

  localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                btn_s1_q, btn_s2_q;
  logic                btn_acc_q, btn_acc_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                press_c;
  logic                load_sw_q;
  logic                load_rise_c;
  logic [BLINK_W-1:0]  blink_q, blink_d;
  logic                blank_q, blank_d;
  logic                dir_q, dir_d;
  logic                count_en_q, count_en_d;
  logic                load_pulse_q, load_pulse_d;
  logic                running_q, done_q;
  logic                term_sw_c, term_dir_c;

  // Debounce: accepted level follows the synchronized level once it has differed for DB_COUNT cycles
  always_comb begin
    db_cnt_d  = '0;
    btn_acc_d = btn_acc_q;
    press_c   = 1'b0;
    if (btn_s2_q != btn_acc_q) begin
      if (db_cnt_q == DB_W'(DB_COUNT - 1)) begin
        btn_acc_d = btn_s2_q;
        press_c   = btn_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign load_rise_c = load_sw & ~load_sw_q;
  assign term_sw_c   = dec_sw ? count_zero : count_max;
  assign term_dir_c  = dir_q  ? count_zero : count_max;

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    blink_d      = blink_q;
    blank_d      = blank_q;
    count_en_d   = 1'b0;
    load_pulse_d = 1'b0;
    case (state_q)
      S_IDLE, S_PAUSE: begin
        if (load_rise_c) begin
          load_pulse_d = 1'b1;
        end else if (press_c) begin
          if (term_sw_c) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            dir_d   = dec_sw;
          end
        end
      end
      S_RUN: begin
        // A terminal tick wins over a same-cycle press
        if (tick_10ms && term_dir_c) begin
          state_d = S_DONE;
        end else begin
          count_en_d = tick_10ms;
          if (press_c) state_d = S_PAUSE;
        end
      end
      S_DONE: begin
        if (tick_10ms) begin
          if (blink_q == BLINK_W'(BLINK_TICKS - 1)) begin
            blink_d = '0;
            blank_d = ~blank_q;
          end else begin
            blink_d = blink_q + BLINK_W'(1);
          end
        end
        if (load_rise_c || press_c) begin
          load_pulse_d = load_rise_c;
          state_d      = S_IDLE;
          blink_d      = '0;
          blank_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      btn_acc_q    <= 1'b0;
      db_cnt_q     <= '0;
      load_sw_q    <= 1'b0;
      blink_q      <= '0;
      blank_q      <= 1'b0;
      dir_q        <= 1'b0;
      count_en_q   <= 1'b0;
      load_pulse_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      btn_s1_q     <= start_btn;
      btn_s2_q     <= btn_s1_q;
      btn_acc_q    <= btn_acc_d;
      db_cnt_q     <= db_cnt_d;
      load_sw_q    <= load_sw;
      blink_q      <= blink_d;
      blank_q      <= blank_d;
      dir_q        <= dir_d;
      count_en_q   <= count_en_d;
      load_pulse_q <= load_pulse_d;
      running_q    <= (state_d == S_RUN);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign count_en   = count_en_q;
  assign load_pulse = load_pulse_q;
  assign dir_down   = dir_q;
  assign running    = running_q;
  assign done       = done_q;
  assign blank      = blank_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model of the stopwatch rules.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int unsigned DB_COUNT    = 4;
  localparam int unsigned DB_W        = 4;
  localparam int unsigned BLINK_TICKS = 2;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0, reset = 1'b0;
  logic tick_10ms = 1'b0, start_btn = 1'b0, load_sw = 1'b0, dec_sw = 1'b0;
  logic count_zero = 1'b0, count_max = 1'b0;
  logic count_en, load_pulse, dir_down, running, done, blank;

  int tests = 0, fails = 0;
  int cen_cnt = 0, lp_cnt = 0, run_rise = 0;
  logic run_prev = 1'b0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DB_COUNT(DB_COUNT), .DB_W(DB_W), .BLINK_TICKS(BLINK_TICKS)) dut (
    .clk(clk), .reset(reset), .tick_10ms(tick_10ms), .start_btn(start_btn),
    .load_sw(load_sw), .dec_sw(dec_sw), .count_zero(count_zero), .count_max(count_max),
    .count_en(count_en), .load_pulse(load_pulse), .dir_down(dir_down),
    .running(running), .done(done), .blank(blank)
  );

  // ---------------- behavioural model ----------------
  int   mode = M_IDLE;
  int   done_ticks = 0;
  bit   m_dir, m_cen, m_lp;
  bit   s1_m, s2_m, acc_m, load_prev;
  bit   hist[$];

  always @(posedge clk) begin
    bit press, lrise, term_sw, term_dir, all_diff;
    if (!reset) begin
      mode = M_IDLE; done_ticks = 0;
      m_dir = 0; m_cen = 0; m_lp = 0;
      s1_m = 0; s2_m = 0; acc_m = 0; load_prev = 0;
      hist.delete();
    end else begin
      // button accepted once the last DB_COUNT synchronized samples all disagree with it
      press = 0;
      hist.push_back(s2_m);
      if (hist.size() > int'(DB_COUNT)) void'(hist.pop_front());
      all_diff = (hist.size() == int'(DB_COUNT));
      foreach (hist[j]) if (hist[j] == acc_m) all_diff = 0;
      if (all_diff) begin
        acc_m = !acc_m;
        press = acc_m;
        hist.delete();
      end
      s2_m = s1_m;
      s1_m = start_btn;
      lrise = load_sw && !load_prev;
      load_prev = load_sw;
      term_sw  = dec_sw ? count_zero : count_max;
      term_dir = m_dir  ? count_zero : count_max;
      m_cen = 0;
      m_lp  = 0;
      if (mode == M_IDLE || mode == M_PAUSE) begin
        if (lrise) m_lp = 1;
        else if (press) begin
          if (term_sw) mode = M_DONE;
          else begin mode = M_RUN; m_dir = dec_sw; end
        end
      end else if (mode == M_RUN) begin
        if (tick_10ms && term_dir) mode = M_DONE;
        else begin
          m_cen = tick_10ms;
          if (press) mode = M_PAUSE;
        end
      end else begin
        if (lrise || press) begin
          m_lp = lrise; mode = M_IDLE; done_ticks = 0;
        end else if (tick_10ms) done_ticks++;
      end
    end
  end

  function automatic logic [5:0] model_vec();
    logic blank_m;
    blank_m = ((done_ticks / int'(BLINK_TICKS)) % 2) != 0;
    return {m_cen, m_lp, m_dir, mode == M_RUN, mode == M_DONE, blank_m};
  endfunction

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [5:0] act, exp;
    act = {count_en, load_pulse, dir_down, running, done, blank};
    exp = reset ? model_vec() : 6'b0;
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL model_cmp t=%0t: got {cen,lp,dir,run,done,blank}=%b expected %b", $time, act, exp);
    end
  end

  // Pulse/edge counters sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (count_en === 1'b1) cen_cnt++;
    if (load_pulse === 1'b1) lp_cnt++;
    if (running === 1'b1 && run_prev !== 1'b1) run_rise++;
    run_prev = running;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn();
    start_btn = 1'b1; cyc(8);
    start_btn = 1'b0; cyc(8);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_10ms = 1'b1; cyc(1);
      tick_10ms = 1'b0; cyc(1);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("async_reset_outputs", 32'({count_en, load_pulse, dir_down, running, done, blank}), 32'd0);
    repeat (n) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, c0, l0, r0;
    bit got;
    logic exp_blank [4];
    exp_blank = '{1'b0, 1'b1, 1'b1, 1'b0};

    cyc(3);
    chk("reset_state", 32'({count_en, load_pulse, dir_down, running, done, blank}), 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    cyc(2);
    chk("idle_after_reset", 32'({running, done, blank}), 32'd0);

    // Held press: IDLE -> RUN after about 2 + DB_COUNT cycles
    start_btn = 1'b1; lat = 0; got = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      cyc(1);
      if (running === 1'b1) begin got = 1; lat = i; end
    end
    chk("press_latency_in_5_to_7", 32'(lat >= 5 && lat <= 7), 32'd1);
    if (lat < 10) cyc(10 - lat);
    start_btn = 1'b0; cyc(8);
    chk("single_press_event", 32'(run_rise), 32'd1);
    c0 = cen_cnt; ticks(5); cyc(1);
    chk("five_ticks_five_count_en", 32'(cen_cnt - c0), 32'd5);

    dec_sw = 1'b1; cyc(4);
    chk("dir_held_in_run", 32'(dir_down), 32'd0);
    dec_sw = 1'b0;

    l0 = lp_cnt; load_sw = 1'b1; cyc(5); load_sw = 1'b0; cyc(2);
    chk("load_ignored_in_run", 32'(lp_cnt - l0), 32'd0);

    press_btn();
    chk("paused", 32'({running, done}), 32'd0);
    c0 = cen_cnt; ticks(3);
    chk("no_count_en_paused", 32'(cen_cnt - c0), 32'd0);
    l0 = lp_cnt; load_sw = 1'b1; cyc(100);
    chk("one_load_pulse_in_pause", 32'(lp_cnt - l0), 32'd1);
    load_sw = 1'b0; cyc(2);
    chk("still_paused_after_load", 32'({running, done}), 32'd0);

    press_btn();
    chk("resumed_run", 32'(running), 32'd1);

    // Terminal tick counting up
    c0 = cen_cnt; count_max = 1'b1; tick_10ms = 1'b1; cyc(1); tick_10ms = 1'b0;
    chk("terminal_done", 32'(done), 32'd1);
    cyc(1);
    chk("terminal_no_count_en", 32'(cen_cnt - c0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick_10ms = 1'b1; cyc(1); tick_10ms = 1'b0; cyc(1);
      chk("blank_sequence", 32'(blank), 32'(exp_blank[i]));
    end
    press_btn();
    chk("done_press_to_idle", 32'({running, done, blank}), 32'd0);
    count_max = 1'b0;

    // Press in IDLE at terminal count down goes straight to DONE
    dec_sw = 1'b1; count_zero = 1'b1; r0 = run_rise; c0 = cen_cnt;
    start_btn = 1'b1; cyc(8); start_btn = 1'b0; cyc(8);
    chk("direct_done", 32'(done), 32'd1);
    chk("direct_done_never_ran", 32'(run_rise - r0), 32'd0);
    chk("direct_done_no_count_en", 32'(cen_cnt - c0), 32'd0);
    l0 = lp_cnt; load_sw = 1'b1; cyc(2);
    chk("load_from_done_pulse", 32'(lp_cnt - l0), 32'd1);
    chk("load_from_done_idle", 32'({running, done}), 32'd0);
    load_sw = 1'b0; dec_sw = 1'b0; count_zero = 1'b0; cyc(2);

    // Press accepted in the same cycle as a terminal tick
    press_btn();
    chk("run_before_race", 32'(running), 32'd1);
    start_btn = 1'b1; cyc(5);
    tick_10ms = 1'b1; count_max = 1'b1; cyc(1); tick_10ms = 1'b0;
    chk("terminal_beats_press", 32'({running, done}), 32'd1);
    cyc(5); start_btn = 1'b0; cyc(8);
    press_btn(); count_max = 1'b0;
    chk("idle_after_race", 32'({running, done}), 32'd0);

    // Bouncing button yields exactly one press
    r0 = run_rise;
    repeat (5) begin
      start_btn = 1'b1; cyc(2);
      start_btn = 1'b0; cyc(2);
    end
    start_btn = 1'b1; cyc(10); start_btn = 1'b0; cyc(8);
    chk("bounce_single_event", 32'(run_rise - r0), 32'd1);
    chk("bounce_in_run", 32'(running), 32'd1);

    // Mid-run asynchronous reset
    do_reset(3);
    cyc(2);
    chk("idle_after_mid_reset", 32'({running, done, blank}), 32'd0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) start_btn = ~start_btn;
      tick_10ms = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) load_sw = ~load_sw;
      if ($urandom_range(0, 29) == 0) dec_sw = ~dec_sw;
      count_zero = ($urandom_range(0, 7) == 0);
      count_max  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 999) == 0) do_reset(2);
      else cyc(1);
    end
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch counter datapath. It debounces the start/stop button and runs a run/pause/done state machine. It gates the 10 ms tick into a count enable, issues load strobes, and freezes the count direction while running. It detects terminal count (00.00 when counting down, 99.99 when counting up) and drives a blink/blank request to the display path when done. It sits between the clock divider, the counter and the display mux.

Parameters:
DB_COUNT, 1000000, consecutive clk cycles a synchronized button level must hold to be accepted (10 ms at 100 MHz)
DB_W, 20, width of debounce counter; must satisfy 2^DB_W > DB_COUNT
BLINK_TICKS, 50, tick_10ms pulses per blank toggle in DONE (0.5 s)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
tick_10ms  in  1  single-cycle enable from clock divider, one per 10 ms
start_btn  in  1  raw asynchronous start/stop push button, active-high
load_sw  in  1  load request switch (level)
dec_sw  in  1  direction switch, 1 = count down
count_zero  in  1  counter reports value 0000
count_max  in  1  counter reports value 9999
count_en  out  1  single-cycle count enable to counter
load_pulse  out  1  single-cycle load strobe to counter
dir_down  out  1  direction to counter, stable while running
running  out  1  high in RUN
done  out  1  high in DONE
blank  out  1  display blank request, toggles in DONE

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; debounce counter 0; accepted button level 0; load_sw edge register 0; blink counter 0.
- Button path: 2-flop synchronizer on start_btn. Debounce counter resets whenever the synchronized level equals the accepted level. Otherwise it increments, and at DB_COUNT the accepted level updates. press = one-cycle pulse on an accepted 0->1 transition. Latency from a stable raw edge: 2 + DB_COUNT cycles, ±1. Release produces no event.
- load_sw: registered; load_rise = load_sw & ~load_sw_q.
- dir_down: loads dec_sw when entering RUN; holds otherwise. Switch changes during RUN/PAUSE/DONE have no effect until the next RUN entry.
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding).
- IDLE:
  - load_rise -> load_pulse=1 for 1 cycle; stay IDLE.
  - Else press -> RUN, unless the run would be terminal: dec_sw=1 & count_zero, or dec_sw=0 & count_max. In that case go to DONE.
- RUN:
  - count_en = tick_10ms, except when tick_10ms coincides with a terminal condition for the latched direction (dir_down & count_zero, or ~dir_down & count_max). Then count_en=0 and next state is DONE.
  - press -> PAUSE.
  - Terminal has priority over a same-cycle press.
  - load_rise is ignored and is not remembered.
- PAUSE:
  - count_en=0.
  - load_rise -> load_pulse, stay PAUSE.
  - press -> RUN (same terminal check as IDLE).
- DONE:
  - count_en=0; done=1.
  - Blink counter counts tick_10ms; at BLINK_TICKS-1 it wraps to 0 and toggles blank.
  - press -> IDLE, with blank=0 and blink counter=0.
  - load_rise -> load_pulse, go to IDLE.
- Simultaneous load_rise and press in IDLE/PAUSE/DONE: the load is taken and the press is dropped.
- running, done and blank are registered and derive from the state. count_en and load_pulse are registered one-cycle outputs: asserted the cycle after the qualifying input, never more than 1 cycle wide.
- Mid-operation reset: immediate return to reset values, regardless of state. Pending debounce progress is discarded.

Test Plan:
- DB_COUNT=4: reset low, then high, press held 10 cycles -> single press; IDLE->RUN with running=1 after 2+4 cycles (±1); 5 ticks -> exactly 5 count_en pulses.
- Press bouncing 0/1 every 2 cycles for 20 cycles, then stable -> exactly one press event; state changes once.
- RUN with dec_sw=0 latched, tick arriving with count_max=1 -> no count_en; done=1 next cycle. Then BLINK_TICKS=2: 4 ticks -> blank toggles 0->1->0.
- PAUSE with load_sw 0->1 -> one load_pulse; held high for 100 cycles -> no further pulses. Load_rise in RUN -> none.
- IDLE with dec_sw=1, count_zero=1, press -> DONE directly; no count_en. dec_sw toggled during RUN -> dir_down unchanged.
- Press and terminal tick in the same RUN cycle -> DONE, not PAUSE. reset=0 asserted mid-RUN -> all outputs 0 asynchronously; IDLE after release.
